// File: rtl/user_data_ram_if.sv
// Bus bundle for user_data_ram: read port, write port, reload request and status.
// Ports: rd_addr/rd_data (registered read), wr_en/wr_addr/wr_data (write), reload,
//        ready (not initialising), dump (whole array packed), par_err (read parity flag).
interface user_data_ram_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0]      rd_addr;
    logic [WIDTH-1:0]       rd_data;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [WIDTH-1:0]       wr_data;
    logic                   reload;
    logic                   ready;
    logic [DEPTH*WIDTH-1:0] dump;
    logic                   par_err;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, reload,
        input  rd_data, ready, dump, par_err
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, reload,
        output rd_data, ready, dump, par_err
    );
endinterface

// File: rtl/user_data_ram.sv
// Small register-file RAM that sweeps an INIT image in after reset or on reload, then serves
// one registered read (1-cycle latency, write-first) and one write per clock.
// No backpressure: ready is low during the DEPTH-edge INIT sweep, writes are ignored then.
// Ports: Clock, Resetn (sync, active-low), bus (user_data_ram_if.slave).
// Optional: define USER_DATA_RAM_PARITY_EN to store an even-parity bit per word and flag
// mismatches on par_err; otherwise par_err is tied to 0.
module user_data_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter logic [DEPTH*WIDTH-1:0] INIT =
          ((DEPTH*WIDTH)'(WIDTH'(8'hFE)))
        | ((DEPTH*WIDTH)'(WIDTH'(8'h03)) << (1*WIDTH))
        | ((DEPTH*WIDTH)'(WIDTH'(8'h04)) << (2*WIDTH))
        | ((DEPTH*WIDTH)'(WIDTH'(8'h01)) << (3*WIDTH))
        | ((DEPTH*WIDTH)'(WIDTH'(8'h03)) << (4*WIDTH))
) (
    input  logic            Clock,
    input  logic            Resetn,
    user_data_ram_if.slave  bus
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic [WIDTH-1:0]  rd_q;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              rd_in;
    logic              wr_in;
    logic              wr_hit;
    logic [WIDTH-1:0]  rd_next;
    logic [WIDTH-1:0]  init_word;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [DEPTH*WIDTH-1:0] dump_v;

    assign rd_in     = ({1'b0, bus.rd_addr} < DEPTH_C);
    assign wr_in     = ({1'b0, bus.wr_addr} < DEPTH_C);
    assign init_word = INIT[int'(init_cnt)*WIDTH +: WIDTH];
    // A reload edge drops the user write, so it must not forward either.
    assign wr_hit    = bus.wr_en && !bus.reload && wr_in && (bus.wr_addr == bus.rd_addr);

    // Single write port shared between the INIT sweep and user writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.wr_data;
        if (state == S_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt;
            mem_wdata = init_word;
        end else if (bus.wr_en && !bus.reload && wr_in) begin
            mem_we = 1'b1;
        end
        // Reset leaves the array alone; the following sweep rewrites it.
        if (!Resetn) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        rd_next = '0;
        if (rd_in) begin
            rd_next = wr_hit ? bus.wr_data : mem[bus.rd_addr];
        end
    end

`ifdef USER_DATA_RAM_PARITY_EN
    logic par_mem [DEPTH];
    logic par_q;
    logic par_next;

    always_ff @(posedge Clock) begin
        if (mem_we) begin
            par_mem[mem_waddr] <= ^mem_wdata;
        end
    end

    // Forwarded write data carries its own fresh parity, so it can never mismatch.
    always_comb begin
        par_next = 1'b0;
        if (rd_in && !wr_hit) begin
            par_next = (^mem[bus.rd_addr]) ^ par_mem[bus.rd_addr];
        end
    end

    assign bus.par_err = par_q;
`else
    assign bus.par_err = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state    <= S_INIT;
            init_cnt <= '0;
            rd_q     <= '0;
`ifdef USER_DATA_RAM_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_INIT: begin
                    rd_q <= '0;
`ifdef USER_DATA_RAM_PARITY_EN
                    par_q <= 1'b0;
`endif
                    if (bus.reload || (init_cnt == LAST)) begin
                        init_cnt <= '0;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                    if (!bus.reload && (init_cnt == LAST)) begin
                        state <= S_RUN;
                    end
                end
                default: begin
                    rd_q <= rd_next;
`ifdef USER_DATA_RAM_PARITY_EN
                    par_q <= par_next;
`endif
                    if (bus.reload) begin
                        state    <= S_INIT;
                        init_cnt <= '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        dump_v = '0;
        for (int i = 0; i < DEPTH; i++) begin
            dump_v[i*WIDTH +: WIDTH] = mem[i];
        end
    end

    assign bus.rd_data = rd_q;
    assign bus.ready   = (state == S_RUN);
    assign bus.dump    = dump_v;
endmodule

// File: doc/user_data_ram.md
USER_DATA_RAM -- requirements
Module: user_data_ram

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (1..32).
REQ-002 SHALL have parameter DEPTH, default 16, number of words (2..256).
REQ-003 SHALL have parameter INIT, default {FE,03,04,01,03, then 11 words of 00} (hex, word 0 first, packed at bit 0 upward), DEPTH*WIDTH-bit power-up/reload image.
REQ-004 SHALL derive ADDR_W = ceil(log2(DEPTH)).
REQ-005 Clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 Resetn  input  1  reset, synchronous, active-low.
REQ-007 rd_addr  input  ADDR_W  read address.
REQ-008 rd_data  output  WIDTH  registered read data.
REQ-009 wr_en  input  1  write strobe.
REQ-010 wr_addr  input  ADDR_W  write address.
REQ-011 wr_data  input  WIDTH  write data.
REQ-012 reload  input  1  request to restore the INIT image.
REQ-013 ready  output  1  high when memory is accessible (not initialising).
REQ-014 dump  output  DEPTH*WIDTH  all words packed, word i at bits [i*WIDTH +: WIDTH]; drives the display path.
REQ-015 par_err  output  1  registered parity error flag for the last read.

Function
REQ-016 SHALL implement a two-state FSM, INIT and RUN, plus a load counter init_cnt (ADDR_W bits).
REQ-017 In INIT, each edge SHALL write INIT word init_cnt to mem[init_cnt] and increment init_cnt; on the edge writing word DEPTH-1 SHALL transition to RUN.
REQ-018 ready SHALL be 1 exactly when state is RUN; after reset release it SHALL rise DEPTH edges after the first edge sampling Resetn high.
REQ-019 In RUN, wr_en=1 with wr_addr<DEPTH SHALL write wr_data to mem[wr_addr] on that edge.
REQ-020 In INIT, wr_en SHALL be ignored.
REQ-021 In RUN, rd_data SHALL update every edge to mem[rd_addr] (1-cycle latency); in INIT, rd_data SHALL load 0.
REQ-022 Read and write to the same address on the same edge SHALL return wr_data (write-first).
REQ-023 Addresses >= DEPTH SHALL read 0 and be ignored for writes.
REQ-024 reload=1 in RUN SHALL enter INIT with init_cnt=0 on that edge; any wr_en on the same edge SHALL be dropped.
REQ-025 reload=1 in INIT SHALL restart init_cnt at 0.
REQ-026 dump SHALL reflect the storage array combinationally, including partial contents during INIT.

Reset
REQ-027 Resetn=0 at an edge SHALL set state=INIT, init_cnt=0, rd_data=0, par_err=0, ready=0, regardless of the operation in progress.
REQ-028 Storage contents SHALL NOT be cleared by reset directly; they are rewritten by the INIT sweep.

Configuration
REQ-029 With macro USER_DATA_RAM_PARITY_EN defined, each word SHALL store an even-parity bit written alongside data (INIT sweep and user writes); par_err SHALL register the parity mismatch of the word read, with the same timing as rd_data, and 0 in INIT or for out-of-range reads.
REQ-030 Without USER_DATA_RAM_PARITY_EN, no parity storage SHALL exist and par_err SHALL be constant 0.

Verification
REQ-031 Defaults; Resetn low 2 edges then high -> ready 0 for 16 edges then 1; dump[39:0] = 0x03010403FE, rest 0.
REQ-032 RUN; rd_addr=0 -> rd_data=0xFE next edge; wr_en=1, wr_addr=5, wr_data=0x7A, rd_addr=5 same edge -> rd_data=0x7A.
REQ-033 RUN; write 0x55 to word 2, then reload=1 with wr_en=1 to word 3 -> ready 0 for 16 edges, word 2 back to 0x04, word 3 stays 0x01.
REQ-034 Resetn low at init_cnt=7 mid-sweep -> next edge init_cnt=0, rd_data=0, full 16-edge sweep repeats.
REQ-035 DEPTH=10, WIDTH=12; read addr 12 -> 0; write addr 12 -> dump unchanged; ready after 10 edges.
REQ-036 USER_DATA_RAM_PARITY_EN defined; force-flip stored data bit 0 of word 1, read addr 1 -> par_err=1 with rd_data=0x02; read addr 0 -> par_err=0.
